// File: rtl/uart_ice40.sv
// Compact full-duplex 8N1 UART for iCE40-class parts.
// TX pin is inverted (idle low); RX pin is normal polarity (idle high).
module uart_ice40 #(
  parameter int SUBDIV16          = 0,
  parameter int ADJUSTSAMPLEPOINT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bitxce,
  input  logic       load,
  input  logic [7:0] d,
  output logic       txpin,
  output logic       txbusy,
  input  logic       rxpin,
  output logic       bytercvd,
  output logic [7:0] q,
  output logic [1:0] rxst
);

  localparam int         T    = 8 * (1 + SUBDIV16);
  localparam logic [3:0] TEND = 4'(T - 1);
  localparam logic [3:0] HEND = 4'(T / 2 - 1 - ADJUSTSAMPLEPOINT);

  typedef enum logic [1:0] {
    HUNT = 2'b00,
    GRCE = 2'b01,
    RECV = 2'b10,
    STOP = 2'b11
  } rx_state_t;

  logic       txbusy_q, txbusy_d;
  logic       txpin_q, txpin_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [3:0] tx_bit_q, tx_bit_d;
  logic [3:0] tx_tick_q, tx_tick_d;

  logic       rx_s1_q, rx_s1_d;
  logic       rx_s2_q, rx_s2_d;
  logic       rx_last_q, rx_last_d;
  rx_state_t  rx_st_q, rx_st_d;
  logic [3:0] rx_tick_q, rx_tick_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] q_q, q_d;
  logic       rcvd_q, rcvd_d;

  // tx_bit: 0 waiting for first tick, 1 start, 2..9 data, 10 stop
  always_comb begin
    txbusy_d  = txbusy_q;
    txpin_d   = txpin_q;
    tx_sr_d   = tx_sr_q;
    tx_bit_d  = tx_bit_q;
    tx_tick_d = tx_tick_q;
    if (!txbusy_q) begin
      if (load) begin
        txbusy_d  = 1'b1;
        tx_sr_d   = d;
        tx_bit_d  = 4'd0;
        tx_tick_d = 4'd0;
      end
    end else if (bitxce) begin
      if (tx_bit_q == 4'd0) begin
        txpin_d   = 1'b1;
        tx_bit_d  = 4'd1;
        tx_tick_d = 4'd0;
      end else if (tx_tick_q != TEND) begin
        tx_tick_d = tx_tick_q + 4'd1;
      end else begin
        tx_tick_d = 4'd0;
        tx_bit_d  = tx_bit_q + 4'd1;
        unique case (1'b1)
          tx_bit_q == 4'd10: begin
            txbusy_d = 1'b0;
            tx_bit_d = 4'd0;
          end
          tx_bit_q == 4'd9: txpin_d = 1'b0;
          default: begin
            txpin_d = ~tx_sr_q[0];
            tx_sr_d = {1'b0, tx_sr_q[7:1]};
          end
        endcase
      end
    end
  end

  always_comb begin
    rx_s1_d   = rxpin;
    rx_s2_d   = rx_s1_q;
    rx_last_d = rx_last_q;
    rx_st_d   = rx_st_q;
    rx_tick_d = rx_tick_q;
    rx_bit_d  = rx_bit_q;
    rx_sr_d   = rx_sr_q;
    q_d       = q_q;
    rcvd_d    = 1'b0;
    if (bitxce) begin
      rx_last_d = rx_s2_q;
      unique case (rx_st_q)
        HUNT: begin
          // edge, not level: a held-low line never restarts
          if (rx_last_q && !rx_s2_q) begin
            rx_st_d   = GRCE;
            rx_tick_d = 4'd0;
          end
        end
        GRCE: begin
          if (rx_tick_q == HEND) begin
            rx_tick_d = 4'd0;
            rx_bit_d  = 3'd0;
            rx_st_d   = rx_s2_q ? HUNT : RECV;
          end else begin
            rx_tick_d = rx_tick_q + 4'd1;
          end
        end
        RECV: begin
          if (rx_tick_q == TEND) begin
            rx_tick_d = 4'd0;
            rx_sr_d   = {rx_s2_q, rx_sr_q[7:1]};
            rx_bit_d  = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_d = STOP;
          end else begin
            rx_tick_d = rx_tick_q + 4'd1;
          end
        end
        STOP: begin
          if (rx_tick_q == TEND) begin
            rx_tick_d = 4'd0;
            rx_st_d   = HUNT;
            if (rx_s2_q) begin
              q_d    = rx_sr_q;
              rcvd_d = 1'b1;
            end
          end else begin
            rx_tick_d = rx_tick_q + 4'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txbusy_q  <= 1'b0;
      txpin_q   <= 1'b0;
      tx_sr_q   <= 8'd0;
      tx_bit_q  <= 4'd0;
      tx_tick_q <= 4'd0;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_last_q <= 1'b1;
      rx_st_q   <= HUNT;
      rx_tick_q <= 4'd0;
      rx_bit_q  <= 3'd0;
      rx_sr_q   <= 8'd0;
      q_q       <= 8'd0;
      rcvd_q    <= 1'b0;
    end else begin
      txbusy_q  <= txbusy_d;
      txpin_q   <= txpin_d;
      tx_sr_q   <= tx_sr_d;
      tx_bit_q  <= tx_bit_d;
      tx_tick_q <= tx_tick_d;
      rx_s1_q   <= rx_s1_d;
      rx_s2_q   <= rx_s2_d;
      rx_last_q <= rx_last_d;
      rx_st_q   <= rx_st_d;
      rx_tick_q <= rx_tick_d;
      rx_bit_q  <= rx_bit_d;
      rx_sr_q   <= rx_sr_d;
      q_q       <= q_d;
      rcvd_q    <= rcvd_d;
    end
  end

  assign txpin    = txpin_q;
  assign txbusy   = txbusy_q;
  assign bytercvd = rcvd_q;
  assign q        = q_q;
  assign rxst     = rx_st_q;

endmodule

// File: tb/tb_uart_ice40.sv
// Bench for uart_ice40: three loopback instances (8-tick, 16-tick,
// tick-per-clock with adjusted sample point) plus forced-RX line tests.
module tb_uart_ice40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic [2:0] div = 3'd0;
  always @(posedge clk) div <= div + 3'd1;

  logic bx8;
  assign bx8 = (div == 3'd7);

  logic [2:0] bxv;
  assign bxv = {1'b1, bx8, bx8};

  logic [2:0] load = 3'b000;
  logic [7:0] din [3] = '{8'h00, 8'h00, 8'h00};
  logic [2:0] txpin, txbusy, rxpin, bytercvd;
  logic [7:0] qo [3];
  logic [1:0] rxst [3];
  logic frc = 1'b0;
  logic fval = 1'b1;

  assign rxpin[0] = frc ? fval : ~txpin[0];
  assign rxpin[1] = ~txpin[1];
  assign rxpin[2] = ~txpin[2];

  uart_ice40 #(.SUBDIV16(0), .ADJUSTSAMPLEPOINT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bitxce(bxv[0]), .load(load[0]),
    .d(din[0]), .txpin(txpin[0]), .txbusy(txbusy[0]),
    .rxpin(rxpin[0]), .bytercvd(bytercvd[0]), .q(qo[0]),
    .rxst(rxst[0]));

  uart_ice40 #(.SUBDIV16(1), .ADJUSTSAMPLEPOINT(0)) u1 (
    .clk(clk), .rst_n(rst_n), .bitxce(bxv[1]), .load(load[1]),
    .d(din[1]), .txpin(txpin[1]), .txbusy(txbusy[1]),
    .rxpin(rxpin[1]), .bytercvd(bytercvd[1]), .q(qo[1]),
    .rxst(rxst[1]));

  uart_ice40 #(.SUBDIV16(0), .ADJUSTSAMPLEPOINT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .bitxce(bxv[2]), .load(load[2]),
    .d(din[2]), .txpin(txpin[2]), .txbusy(txbusy[2]),
    .rxpin(rxpin[2]), .bytercvd(bytercvd[2]), .q(qo[2]),
    .rxst(rxst[2]));

  int rcv_cnt [3] = '{0, 0, 0};
  always @(negedge clk)
    for (int k = 0; k < 3; k++)
      if (bytercvd[k]) rcv_cnt[k] <= rcv_cnt[k] + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cpt(input int k);
    return (k == 2) ? 1 : 8;
  endfunction

  function automatic int tlen(input int k);
    return (k == 1) ? 16 : 8;
  endfunction

  // wire level of frame bit i: start 1, inverted data LSB first, stop 0
  function automatic logic exp_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b1;
    if (i == 9) return 1'b0;
    return ~b[i-1];
  endfunction

  task automatic send_check(input int k, input logic [7:0] b,
                            input bit inject);
    int n0, w, cur, tgt, t, c;
    t  = tlen(k);
    c  = cpt(k);
    n0 = rcv_cnt[k];
    @(negedge clk);
    load[k] = 1'b1;
    din[k]  = b;
    @(negedge clk);
    load[k] = 1'b0;
    chk($sformatf("busy_set%0d", k), 32'(txbusy[k]), 32'd1);
    w = 0;
    while (txpin[k] !== 1'b1 && w < 64) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("start_seen%0d", k), 32'(w < 64), 32'd1);
    cur = 0;
    for (int i = 0; i < 10; i++) begin
      tgt = (i * t + t / 2) * c;
      while (cur < tgt) begin
        @(negedge clk);
        cur++;
      end
      chk($sformatf("txbit%0d_%0d", k, i), 32'(txpin[k]),
          32'(exp_bit(b, i)));
      if (inject && i == 3) begin
        load[k] = 1'b1;
        din[k]  = 8'h4E;
        @(negedge clk);
        cur++;
        load[k] = 1'b0;
        din[k]  = b;
      end
    end
    while (cur < 10 * t * c - 1) begin
      @(negedge clk);
      cur++;
    end
    chk($sformatf("busy_hold%0d", k), 32'(txbusy[k]), 32'd1);
    @(negedge clk);
    chk($sformatf("busy_drop%0d", k), 32'(txbusy[k]), 32'd0);
    chk($sformatf("rx_count%0d", k), 32'(rcv_cnt[k] - n0), 32'd1);
    chk($sformatf("rx_data%0d", k), 32'(qo[k]), 32'(b));
    chk($sformatf("rx_idle%0d", k), 32'(rxst[k]), 32'd0);
  endtask

  initial begin
    int n0, bad;
    logic saw;
    logic [7:0] qprev, rb;

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_txpin%0d", k), 32'(txpin[k]), 32'd0);
      chk($sformatf("rst_txbusy%0d", k), 32'(txbusy[k]), 32'd0);
      chk($sformatf("rst_rcvd%0d", k), 32'(bytercvd[k]), 32'd0);
      chk($sformatf("rst_q%0d", k), 32'(qo[k]), 32'd0);
      chk($sformatf("rst_rxst%0d", k), 32'(rxst[k]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      send_check(k, 8'hC1, 1'b1);
      repeat (20) @(negedge clk);
      chk($sformatf("ignored_load%0d", k), 32'(txbusy[k]), 32'd0);
      send_check(k, 8'h4E, 1'b0);
      for (int j = 0; j < 3; j++) begin
        rb = 8'($urandom_range(0, 255));
        send_check(k, rb, 1'b0);
      end
    end

    // short low glitch on an idle line
    frc  = 1'b1;
    fval = 1'b1;
    repeat (16) @(negedge clk);
    n0   = rcv_cnt[0];
    saw  = 1'b0;
    fval = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rxst[0] != 2'b00) saw = 1'b1;
    end
    fval = 1'b1;
    repeat (56) begin
      @(negedge clk);
      if (rxst[0] != 2'b00) saw = 1'b1;
    end
    chk("glitch_left_hunt", 32'(saw), 32'd1);
    chk("glitch_back_hunt", 32'(rxst[0]), 32'd0);
    repeat (100) @(negedge clk);
    chk("glitch_no_byte", 32'(rcv_cnt[0] - n0), 32'd0);

    // break: line held low for 16 bit periods
    qprev = qo[0];
    n0    = rcv_cnt[0];
    saw   = 1'b0;
    fval  = 1'b0;
    repeat (16 * 64) begin
      @(negedge clk);
      if (rxst[0] == 2'b10) saw = 1'b1;
    end
    fval = 1'b1;
    repeat (20) @(negedge clk);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (rxst[0] != 2'b00) bad++;
    end
    chk("break_tried_recv", 32'(saw), 32'd1);
    chk("break_hunt_steady", 32'(bad), 32'd0);
    chk("break_no_byte", 32'(rcv_cnt[0] - n0), 32'd0);
    chk("break_q_kept", 32'(qo[0]), 32'(qprev));
    frc = 1'b0;
    repeat (16) @(negedge clk);

    // reset in the middle of a looped-back frame
    n0 = rcv_cnt[0];
    @(negedge clk);
    load[0] = 1'b1;
    din[0]  = 8'hA5;
    @(negedge clk);
    load[0] = 1'b0;
    repeat (3 * 64) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_txpin", 32'(txpin[0]), 32'd0);
    chk("midrst_txbusy", 32'(txbusy[0]), 32'd0);
    chk("midrst_rxst", 32'(rxst[0]), 32'd0);
    chk("midrst_q", 32'(qo[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_no_byte", 32'(rcv_cnt[0] - n0), 32'd0);
    rb = 8'($urandom_range(0, 255));
    send_check(0, rb, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_ice40.md
Name: uart_ice40

Overview:
- Compact full-duplex 8N1 UART (transmitter and receiver) for iCE40-class FPGAs.
- Bit timing comes from an external clock-enable `bitxce`; each bit lasts 8 ticks (SUBDIV16=0) or 16 ticks (SUBDIV16=1).
- The transmit pin is driven inverted (idle low) so its register resets to 0. The receive pin uses normal polarity (idle high).
- Instantiated once per serial link; TX and RX halves are independent.

Parameters:
- SUBDIV16, 0, bit period = 8*(1+SUBDIV16) bitxce ticks.
- ADJUSTSAMPLEPOINT, 0, set to 1 when bitxce is tied high (ticks = clocks); moves the RX sample point one tick earlier to compensate for synchroniser latency.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- bitxce  in  1  bit-tick clock enable
- load  in  1  one-clock request to transmit d
- d  in  8  byte to transmit
- txpin  out  1  serial output, inverted polarity (idle 0, start 1, data ~bit, stop 0)
- txbusy  out  1  transmitter busy
- rxpin  in  1  serial input, normal polarity (idle 1, start 0)
- bytercvd  out  1  one-clock pulse: valid byte in q
- q  out  8  last received byte
- rxst  out  2  receiver state: 00 HUNT, 01 GRCE, 10 RECV, 11 STOP

Behaviour:
Reset (rst_n=0, async):
- txpin=0, txbusy=0, bytercvd=0, q=0, rxst=HUNT (00).
- All counters and shift registers cleared.
- RX synchroniser flops set to 1 (idle).

TX:
- load is sampled on every clk, regardless of bitxce.
- If txbusy=0 on a load cycle: latch d, set txbusy=1 on the next clk.
- If txbusy=1 on a load cycle: load is ignored.
- Frame on the wire, bits LSB first: start(1), ~d[0]..~d[7], stop(0).
- Each bit lasts T=8*(1+SUBDIV16) bitxce ticks; the start bit begins at the first bitxce after the latch.
- txbusy drops after the stop bit's T ticks complete; a new load is accepted from that cycle on.
- Frame length is 10*T ticks.

RX:
- rxpin passes through a 2-flop synchroniser; state changes only on bitxce ticks.
- HUNT: a start is detected on a 1->0 transition of the synchronised input, not on a static low. Go to GRCE and clear the tick counter.
- GRCE: at tick T/2 (T/2-1 if ADJUSTSAMPLEPOINT=1):
  - input low -> RECV;
  - input high -> HUNT (false-start rejection).
- RECV: sample every T ticks; shift in 8 bits LSB first, then go to STOP.
- STOP: sample after T ticks.
  - High: q <= shifted byte, bytercvd=1 for exactly one clk, go to HUNT.
  - Low (frame error/break): q unchanged, no pulse, go to HUNT.
- After a frame error, no new start is detected until the line has returned high (falling-edge rule).
- q holds its value until the next good byte.
- Mid-frame reset aborts immediately; no partial byte reaches q.

Test Plan:
- SUBDIV16=0, bitxce every 8th clk; TX txpin looped to RX rxpin through an inverter. Load d=0xC1 -> txbusy high for 10 bit periods; bytercvd pulses once with q=0xC1.
- Assert load with d=0x4E while txbusy=1 -> ignored. Load 0x4E after idle -> q=0x4E.
- Drive rxpin low for 8 clks (~1 tick) from idle -> rxst leaves HUNT, is back at 00 within T/2 ticks; no bytercvd.
- Hold rxpin low from one bit before a frame until 1.5 frames later -> no bytercvd. rxst=00 continuously from 2 ticks after rxpin returns high.
- Repeat tests 1-2 with SUBDIV16=1, and with bitxce=1 plus ADJUSTSAMPLEPOINT=1 -> same data received.
- Assert rst_n low mid-transmit and mid-receive -> txpin=0, txbusy=0, rxst=00 immediately; the next full frame is received correctly.
